// File: rtl/demux8_frame_tx_if.sv
// Signal bundle between a frame requester and the demux8_frame_tx serializer.
// The master drives the request and word; the slave (the serializer) drives the lane signals.
interface demux8_frame_tx_if;
    logic       START;
    logic [7:0] DIN;
    logic       D;
    logic [2:0] S;
    logic       E;
    logic       BUSY;
    logic       DONE;

    modport master (
        output START, DIN,
        input  D, S, E, BUSY, DONE
    );

    modport slave (
        input  START, DIN,
        output D, S, E, BUSY, DONE
    );
endinterface

// File: rtl/demux8_frame_tx.sv
// Transmit end of the 1:8 demultiplexed lane link: shifts an 8-bit word out LSB first on D/S/E.
// Define DEMUX8_FRAME_TX_AUTO_RELOAD_EN to chain back-to-back frames when START is seen on the last slot.
module demux8_frame_tx #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    demux8_frame_tx_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [7:0] shadow;
    logic [2:0] slot;
    logic [7:0] hold;

    logic       last_hold;
    logic [2:0] next_slot;
    logic       reload;

    assign last_hold = (hold == HOLD_LAST);
    assign next_slot = slot + 3'd1;

`ifdef DEMUX8_FRAME_TX_AUTO_RELOAD_EN
    assign reload = bus.START;
`else
    assign reload = 1'b0;
`endif

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples pre-edge values; outputs are computed one cycle ahead to stay registered.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            shadow   <= 8'h00;
            slot     <= 3'd0;
            hold     <= 8'h00;
            bus.D    <= 1'b0;
            bus.S    <= 3'd0;
            bus.E    <= 1'b0;
            bus.BUSY <= 1'b0;
            bus.DONE <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        shadow   <= bus.DIN;
                        slot     <= 3'd0;
                        hold     <= 8'h00;
                        state    <= ST_SEND;
                        bus.E    <= 1'b1;
                        bus.BUSY <= 1'b1;
                        bus.S    <= 3'd0;
                        bus.D    <= bus.DIN[0];
                    end
                end

                ST_SEND: begin
                    if (!last_hold) begin
                        hold <= hold + 8'd1;
                    end else if (slot != 3'd7) begin
                        hold  <= 8'h00;
                        slot  <= next_slot;
                        bus.S <= next_slot;
                        bus.D <= shadow[next_slot];
                    end else if (reload) begin
                        // Chained frame: E and BUSY stay high, DONE marks slot 0 of the new word.
                        shadow   <= bus.DIN;
                        slot     <= 3'd0;
                        hold     <= 8'h00;
                        bus.S    <= 3'd0;
                        bus.D    <= bus.DIN[0];
                        bus.DONE <= 1'b1;
                    end else begin
                        slot     <= 3'd0;
                        hold     <= 8'h00;
                        state    <= ST_DONE;
                        bus.E    <= 1'b0;
                        bus.BUSY <= 1'b0;
                        bus.DONE <= 1'b1;
                        bus.S    <= 3'd0;
                        bus.D    <= 1'b0;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
